// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port (fetch/data) memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int RAM_LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one fixed-latency RAM.
// Handshake: a port holds req (with its address/data) until its one-cycle ack; a request still high after ack is a new one.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_LAT = RAM_LAT_DEFAULT,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    output logic          ram_we,
    input  logic [31:0]   ram_rdata,
    output logic          stall
);

    localparam logic [3:0] CNT_INIT = 4'(RAM_LAT - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic       cur_port;
    logic       last_port;
    logic       grant_valid;
    logic       grant_port;

    // On a tie the port that was not served last wins.
    always_comb begin
        grant_valid = if_req | d_req;
        if (if_req && d_req) begin
            grant_port = (last_port == PORT_D) ? PORT_IF : PORT_D;
        end else if (d_req) begin
            grant_port = PORT_D;
        end else begin
            grant_port = PORT_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_valid) state_nx = BUSY;
            BUSY:    if (cnt == 4'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        if_ack = (state == DONE) && (cur_port == PORT_IF);
        d_ack  = (state == DONE) && (cur_port == PORT_D);
        stall  = (if_req & ~if_ack) | (d_req & ~d_ack);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            cur_port  <= PORT_IF;
            last_port <= PORT_D;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        ram_addr  <= (grant_port == PORT_D) ? d_addr : if_addr;
                        ram_we    <= (grant_port == PORT_D) & d_we;
                        ram_wdata <= d_wdata;
                        cnt       <= CNT_INIT;
                        cur_port  <= grant_port;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        // ram_we still marks the transaction type on this last busy cycle.
                        ram_we <= 1'b0;
                        if (!ram_we) begin
                            if (cur_port == PORT_IF) begin
                                if_rdata <= ram_rdata;
                            end else begin
                                d_rdata <= ram_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    last_port <= cur_port;
                end
                default: begin
                    cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RAM_LAT, default 2: fixed RAM access latency in cycles, legal range 1..15.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  instruction-fetch request, held until if_ack.
REQ-006 if_addr  in  AW  fetch byte address.
REQ-007 if_ack  out  1  one-cycle completion pulse for the fetch port.
REQ-008 if_rdata  out  32  fetched word, registered.
REQ-009 d_req  in  1  data request, held until d_ack.
REQ-010 d_we  in  1  data write enable, qualifies d_req.
REQ-011 d_addr  in  AW  data byte address.
REQ-012 d_wdata  in  32  store data.
REQ-013 d_ack  out  1  one-cycle completion pulse for the data port.
REQ-014 d_rdata  out  32  load word, registered.
REQ-015 ram_addr  out  AW  shared RAM address, registered.
REQ-016 ram_wdata  out  32  shared RAM write data, registered.
REQ-017 ram_we  out  1  shared RAM write strobe.
REQ-018 ram_rdata  in  32  shared RAM read data, valid RAM_LAT cycles after ram_addr changes.
REQ-019 stall  out  1  pipeline freeze: (if_req & ~if_ack) | (d_req & ~d_ack), combinational.

Function
REQ-020 FSM states IDLE, BUSY, DONE; IDLE samples requests, BUSY waits RAM latency, DONE pulses ack.
REQ-021 IDLE with exactly one request: grant it; with both: grant the port not served last (round-robin); with none: stay IDLE.
REQ-022 On grant: latch address, d_we (forced 0 for fetch), d_wdata into ram_addr/ram_we/ram_wdata, load counter with RAM_LAT-1, record granted port, go BUSY.
REQ-023 BUSY: counter==0 -> capture ram_rdata into granted port's rdata register (reads only), go DONE; else decrement.
REQ-024 ram_we SHALL be high for every BUSY cycle of a write and low in all other cycles.
REQ-025 DONE: assert granted port's ack for exactly one cycle, update last-served to that port, go IDLE.
REQ-026 Latency: request seen in IDLE cycle t -> ack in cycle t+RAM_LAT+1; back-to-back grants separated by one IDLE cycle.
REQ-027 Request held high in the IDLE cycle after its ack is a new transaction.
REQ-028 Request deasserted during BUSY does not abort; transaction completes and ack pulses.
REQ-029 Writes leave d_rdata unchanged; if_rdata/d_rdata hold until the next read completion on that port.
REQ-030 if_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-031 rst high at a clock edge: state IDLE, counter 0, last-served = data port (first conflict grants fetch).
REQ-032 Reset values: if_ack=0, d_ack=0, ram_we=0, ram_addr=0, ram_wdata=0, if_rdata=0, d_rdata=0.
REQ-033 Reset mid-transaction discards it; no ack is issued for it.

Structure
REQ-034 Shared package holds the FSM state enum, the port-id constants (PORT_IF, PORT_D) and the default RAM_LAT.
REQ-035 Single flat module; no sub-module.

Verification (RAM_LAT=2)
REQ-036 Fetch only, if_addr=0x100, ram_rdata=0xDEADBEEF -> if_ack at t+3, if_rdata=0xDEADBEEF, ram_we never high.
REQ-037 Store d_addr=0x40, d_wdata=0x12345678 -> ram_we high exactly 2 cycles with ram_addr=0x40, d_ack at t+3, d_rdata unchanged.
REQ-038 if_req and d_req both rise after reset -> fetch acked at t+3, data granted t+4, d_ack at t+7; next conflict -> fetch served first.
REQ-039 rst asserted in second BUSY cycle of a read -> no ack afterwards, all outputs at reset values next cycle, next request acked at normal latency.
REQ-040 RAM_LAT=1, fetch held continuously -> if_ack every 3 cycles, never two consecutive cycles.
